// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: grants up to two completing producers per cycle
// in round-robin order and registers the winners onto the two CDB slots.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_value,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [TAG_W-1:0]          cdb_tag1,
  output logic [DATA_W-1:0]         cdb_value1,
  output logic [TAG_W-1:0]          cdb_tag2,
  output logic [DATA_W-1:0]         cdb_value2,
  output logic [31:0]               denied_count
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(NUM_REQ + 1);

  // Round-robin scan position: pointer advanced by k, wrapping at NUM_REQ.
  function automatic logic [PTR_W-1:0] wrap_add(
    input logic [PTR_W-1:0] p,
    input int               k
  );
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  // Index one past p, wrapping NUM_REQ-1 back to 0.
  function automatic logic [PTR_W-1:0] inc_wrap(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [PTR_W-1:0]   r_rr_ptr;
  logic [TAG_W-1:0]   r_tag1;
  logic [TAG_W-1:0]   r_tag2;
  logic [DATA_W-1:0]  r_val1;
  logic [DATA_W-1:0]  r_val2;
  logic [31:0]        r_denied;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_zero;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_hit1;
  logic               w_hit2;
  logic [PTR_W-1:0]   w_idx1;
  logic [PTR_W-1:0]   w_idx2;
  logic [CNT_W-1:0]   w_elig_cnt;
  logic [CNT_W-1:0]   w_gnt_cnt;
  logic [32:0]        w_den_sum;
  logic [31:0]        w_denied_nxt;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [TAG_W-1:0]   w_tag1;
  logic [TAG_W-1:0]   w_tag2;
  logic [DATA_W-1:0]  w_val1;
  logic [DATA_W-1:0]  w_val2;

  // Classify each requester: real broadcast vs zero-tag no-op.
  always_comb begin
    w_elig = '0;
    w_zero = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_zero[i] = req_valid[i] &&
                  (req_tag[i*TAG_W +: TAG_W] == '0);
      w_elig[i] = req_valid[i] &&
                  (req_tag[i*TAG_W +: TAG_W] != '0);
    end
  end

  // Scan from the pointer; first two eligible requesters win.
  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    w_idx1 = '0;
    w_idx2 = '0;
    if (!flush) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (w_elig[wrap_add(r_rr_ptr, k)]) begin
          if (!w_hit1) begin
            w_hit1 = 1'b1;
            w_idx1 = wrap_add(r_rr_ptr, k);
          end else if (!w_hit2) begin
            w_hit2 = 1'b1;
            w_idx2 = wrap_add(r_rr_ptr, k);
          end
        end
      end
    end
  end

  // One-hot grant vector built from the two winning indices.
  always_comb begin
    w_gnt = '0;
    if (w_hit1) w_gnt[w_idx1] = 1'b1;
    if (w_hit2) w_gnt[w_idx2] = 1'b1;
  end

  // Accept winners and zero-tag no-ops; nothing during reset or flush.
  always_comb begin
    req_ready = '0;
    if (!reset && !flush) req_ready = w_gnt | w_zero;
  end

  // Slot payload mux; an empty slot carries tag 0 and value 0.
  always_comb begin
    w_tag1 = '0;
    w_val1 = '0;
    w_tag2 = '0;
    w_val2 = '0;
    if (w_hit1) begin
      w_tag1 = req_tag[w_idx1*TAG_W +: TAG_W];
      w_val1 = req_value[w_idx1*DATA_W +: DATA_W];
    end
    if (w_hit2) begin
      w_tag2 = req_tag[w_idx2*TAG_W +: TAG_W];
      w_val2 = req_value[w_idx2*DATA_W +: DATA_W];
    end
  end

  // Denied requester-cycles this cycle, added with saturation.
  always_comb begin
    w_elig_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig_cnt = w_elig_cnt + CNT_W'(w_elig[i]);
    end
    w_gnt_cnt    = CNT_W'(w_hit1) + CNT_W'(w_hit2);
    w_den_sum    = {1'b0, r_denied} +
                   33'(w_elig_cnt - w_gnt_cnt);
    w_denied_nxt = w_den_sum[32] ? 32'hFFFF_FFFF
                                 : w_den_sum[31:0];
  end

  // Pointer moves past the last winner; flush restarts it at 0.
  always_comb begin
    w_ptr_nxt = r_rr_ptr;
    if (flush)       w_ptr_nxt = '0;
    else if (w_hit2) w_ptr_nxt = inc_wrap(w_idx2);
    else if (w_hit1) w_ptr_nxt = inc_wrap(w_idx1);
  end

  // Register slots, pointer and denied counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
      r_tag1   <= '0;
      r_val1   <= '0;
      r_tag2   <= '0;
      r_val2   <= '0;
      r_denied <= '0;
    end else begin
      r_rr_ptr <= w_ptr_nxt;
      r_tag1   <= w_tag1;
      r_val1   <= w_val1;
      r_tag2   <= w_tag2;
      r_val2   <= w_val2;
      if (!flush) r_denied <= w_denied_nxt;
    end
  end

  assign cdb_tag1     = r_tag1;
  assign cdb_value1   = r_val1;
  assign cdb_tag2     = r_tag2;
  assign cdb_value2   = r_val2;
  assign denied_count = r_denied;

  // Two producers must never broadcast the same tag together.
  a_dup_tag: assert property (
    @(posedge clk) disable iff (reset)
    (w_hit1 && w_hit2) |-> (w_tag1 != w_tag2)
  );

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized traffic
// compared against a round-robin reference model.
module tb_cdb_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic [3:0]   req_valid;
  logic [127:0] req_tag;
  logic [127:0] req_value;
  logic [3:0]   req_ready;
  logic [31:0]  cdb_tag1;
  logic [31:0]  cdb_value1;
  logic [31:0]  cdb_tag2;
  logic [31:0]  cdb_value2;
  logic [31:0]  denied_count;

  int total = 0;
  int bad   = 0;

  int          m_ptr;
  longint      m_denied;
  logic [3:0]  e_ready;
  logic [31:0] e_t1, e_v1, e_t2, e_v2;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(4), .TAG_W(32), .DATA_W(32)) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .req_valid(req_valid),
    .req_tag(req_tag),
    .req_value(req_value),
    .req_ready(req_ready),
    .cdb_tag1(cdb_tag1),
    .cdb_value1(cdb_value1),
    .cdb_tag2(cdb_tag2),
    .cdb_value2(cdb_value2),
    .denied_count(denied_count)
  );

  // Reference: evaluates one cycle from the current inputs; e_ready is
  // this cycle's accept set, e_t*/e_v* the next-cycle CDB contents.
  task automatic model_cycle();
    int cnt;
    int elig;
    int last;
    int j;
    logic [31:0] t;
    e_ready = '0;
    e_t1 = 0; e_v1 = 0; e_t2 = 0; e_v2 = 0;
    cnt = 0; elig = 0; last = 0;
    if (flush) begin
      m_ptr = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        t = req_tag[i*32 +: 32];
        if (req_valid[i] && t == 0) e_ready[i] = 1'b1;
        if (req_valid[i] && t != 0) elig++;
      end
      for (int k = 0; k < 4; k++) begin
        j = (m_ptr + k) % 4;
        t = req_tag[j*32 +: 32];
        if (req_valid[j] && t != 0 && cnt < 2) begin
          if (cnt == 0) begin
            e_t1 = t; e_v1 = req_value[j*32 +: 32];
          end else begin
            e_t2 = t; e_v2 = req_value[j*32 +: 32];
          end
          e_ready[j] = 1'b1;
          last = j;
          cnt++;
        end
      end
      if (cnt > 0) m_ptr = (last + 1) % 4;
      m_denied = m_denied + elig - cnt;
      if (m_denied > 64'hFFFF_FFFF) m_denied = 64'hFFFF_FFFF;
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] t,
                         input logic [31:0] v);
    req_valid[i] = 1'b1;
    req_tag[i*32 +: 32] = t;
    req_value[i*32 +: 32] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0;
    req_valid = '0;
    req_tag = '0;
    req_value = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_ptr = 0;
    m_denied = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    req_valid = '0;
    for (int i = 0; i < 4; i++) set_req(i, 5 + i, 100 + i);
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ready got=%b want=0000", req_ready);
    end
    total++;
    if (cdb_tag1 !== 0 || cdb_tag2 !== 0) begin
      bad++;
      $display("FAIL reset_tags got=%0d,%0d want=0,0",
               cdb_tag1, cdb_tag2);
    end
    total++;
    if (cdb_value1 !== 0 || cdb_value2 !== 0) begin
      bad++;
      $display("FAIL reset_vals got=%h,%h want=0,0",
               cdb_value1, cdb_value2);
    end
    total++;
    if (denied_count !== 0) begin
      bad++;
      $display("FAIL reset_denied got=%0d want=0", denied_count);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_ptr = 0;
    m_denied = 0;
    model_cycle();
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0011) begin
      bad++;
      $display("FAIL post_reset_ready got=%b want=0011", req_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if (cdb_tag1 !== 5 || cdb_tag2 !== 6) begin
      bad++;
      $display("FAIL post_reset_tags got=%0d,%0d want=5,6",
               cdb_tag1, cdb_tag2);
    end
    total++;
    if (cdb_value1 !== 100 || cdb_value2 !== 101) begin
      bad++;
      $display("FAIL post_reset_vals got=%0d,%0d want=100,101",
               cdb_value1, cdb_value2);
    end
  endtask

  task automatic test_all_four();
    logic [31:0] w1 [4];
    logic [31:0] w2 [4];
    w1 = '{10, 12, 0, 0};
    w2 = '{11, 13, 0, 0};
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 10 + i, $urandom);
    for (int c = 0; c < 4; c++) begin
      model_cycle();
      @(negedge clk);
      total++;
      if (req_ready !== e_ready) begin
        bad++;
        $display("FAIL all4_ready c=%0d got=%b want=%b",
                 c, req_ready, e_ready);
      end
      @(posedge clk);
      #1;
      total++;
      if (cdb_tag1 !== w1[c] || cdb_tag2 !== w2[c]) begin
        bad++;
        $display("FAIL all4_tags c=%0d got=%0d,%0d want=%0d,%0d",
                 c, cdb_tag1, cdb_tag2, w1[c], w2[c]);
      end
      total++;
      if (cdb_value1 !== e_v1 || cdb_value2 !== e_v2) begin
        bad++;
        $display("FAIL all4_vals c=%0d got=%h,%h want=%h,%h",
                 c, cdb_value1, cdb_value2, e_v1, e_v2);
      end
      total++;
      if (denied_count !== 2) begin
        bad++;
        $display("FAIL all4_denied c=%0d got=%0d want=2",
                 c, denied_count);
      end
      req_valid = req_valid & ~e_ready;
    end
  endtask

  task automatic test_single_and_wrap();
    do_reset();
    set_req(2, 7, 32'hDEAD_BEEF);
    model_cycle();
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL single_ready got=%b want=0100", req_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if (cdb_tag1 !== 7 || cdb_value1 !== 32'hDEAD_BEEF ||
        cdb_tag2 !== 0 || cdb_value2 !== 0) begin
      bad++;
      $display("FAIL single_cdb got=%0d/%h,%0d/%h want=7/deadbeef,0/0",
               cdb_tag1, cdb_value1, cdb_tag2, cdb_value2);
    end
    req_valid = '0;
    set_req(3, 20, 32'h3333);
    set_req(0, 21, 32'h0000_1111);
    model_cycle();
    @(negedge clk);
    total++;
    if (req_ready !== 4'b1001) begin
      bad++;
      $display("FAIL wrap_ready got=%b want=1001", req_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if (cdb_tag1 !== 20 || cdb_tag2 !== 21) begin
      bad++;
      $display("FAIL wrap_tags got=%0d,%0d want=20,21",
               cdb_tag1, cdb_tag2);
    end
    req_valid = '0;
    for (int i = 0; i < 4; i++) set_req(i, 30 + i, 0);
    model_cycle();
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0110) begin
      bad++;
      $display("FAIL ptr1_ready got=%b want=0110", req_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if (cdb_tag1 !== 31 || cdb_tag2 !== 32) begin
      bad++;
      $display("FAIL ptr1_tags got=%0d,%0d want=31,32",
               cdb_tag1, cdb_tag2);
    end
    req_valid = '0;
  endtask

  task automatic test_zero_tag();
    do_reset();
    set_req(1, 0, 32'h5555);
    set_req(2, 9, 32'h9999);
    model_cycle();
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0110) begin
      bad++;
      $display("FAIL zero_ready got=%b want=0110", req_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if (cdb_tag1 !== 9 || cdb_value1 !== 32'h9999 || cdb_tag2 !== 0) begin
      bad++;
      $display("FAIL zero_cdb got=%0d/%h,%0d want=9/9999,0",
               cdb_tag1, cdb_value1, cdb_tag2);
    end
    total++;
    if (denied_count !== 0) begin
      bad++;
      $display("FAIL zero_denied got=%0d want=0", denied_count);
    end
    req_valid = '0;
  endtask

  task automatic test_flush();
    do_reset();
    set_req(2, 3, 32'h77);
    model_cycle();
    @(posedge clk);
    #1;
    req_valid = '0;
    for (int i = 0; i < 4; i++) set_req(i, 40 + i, 400 + i);
    flush = 1'b1;
    model_cycle();
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL flush_ready got=%b want=0000", req_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if (cdb_tag1 !== 0 || cdb_tag2 !== 0) begin
      bad++;
      $display("FAIL flush_tags got=%0d,%0d want=0,0",
               cdb_tag1, cdb_tag2);
    end
    total++;
    if (denied_count !== 0) begin
      bad++;
      $display("FAIL flush_denied got=%0d want=0", denied_count);
    end
    flush = 1'b0;
    model_cycle();
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0011) begin
      bad++;
      $display("FAIL after_flush_ready got=%b want=0011", req_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if (cdb_tag1 !== 40 || cdb_tag2 !== 41) begin
      bad++;
      $display("FAIL after_flush_tags got=%0d,%0d want=40,41",
               cdb_tag1, cdb_tag2);
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    int next_tag;
    next_tag = 100;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i] && ($urandom % 2 == 0)) begin
          if ($urandom % 8 == 0) begin
            set_req(i, 0, $urandom);
          end else begin
            set_req(i, next_tag, $urandom);
            next_tag++;
          end
        end
      end
      flush = ($urandom % 12 == 0);
      model_cycle();
      @(negedge clk);
      total++;
      if (req_ready !== e_ready) begin
        bad++;
        $display("FAIL rnd_ready c=%0d got=%b want=%b",
                 c, req_ready, e_ready);
      end
      @(posedge clk);
      #1;
      total++;
      if (cdb_tag1 !== e_t1 || cdb_value1 !== e_v1 ||
          cdb_tag2 !== e_t2 || cdb_value2 !== e_v2) begin
        bad++;
        $display("FAIL rnd_cdb c=%0d got=%0d/%h,%0d/%h want=%0d/%h,%0d/%h",
                 c, cdb_tag1, cdb_value1, cdb_tag2, cdb_value2,
                 e_t1, e_v1, e_t2, e_v2);
      end
      total++;
      if (denied_count !== m_denied[31:0]) begin
        bad++;
        $display("FAIL rnd_denied c=%0d got=%0d want=%0d",
                 c, denied_count, m_denied[31:0]);
      end
      req_valid = req_valid & ~e_ready;
    end
    flush = 1'b0;
    req_valid = '0;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    req_valid = '0;
    req_tag = '0;
    req_value = '0;
    m_ptr = 0;
    m_denied = 0;
    test_reset();
    test_all_four();
    test_single_and_wrap();
    test_zero_tag();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the two common-data-bus (CDB) broadcast slots among NUM_REQ completing producers (ALU pipes, load unit, branch unit).
- Grants up to two requesters per cycle in round-robin order and registers the winners onto cdb_tag1/cdb_value1 and cdb_tag2/cdb_value2.
- Sits between the execute/memory stages and the commit stage, reservation stations and ROB.
- Tag 0 means "no broadcast", matching the codebase CDB convention.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- TAG_W, 32: tag width (int).
- DATA_W, 32: value width (MemoryWord).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  pipeline flush (branch mispredict); squashes this cycle's arbitration.
- req_valid  input  NUM_REQ  per-requester valid.
- req_tag  input  NUM_REQ*TAG_W  flattened tags; requester i occupies bits [i*TAG_W +: TAG_W].
- req_value  input  NUM_REQ*DATA_W  flattened values; same packing as req_tag.
- req_ready  output  NUM_REQ  per-requester accept, combinational.
- cdb_tag1  output  TAG_W  slot-1 broadcast tag (0 = idle).
- cdb_value1  output  DATA_W  slot-1 value.
- cdb_tag2  output  TAG_W  slot-2 broadcast tag (0 = idle).
- cdb_value2  output  DATA_W  slot-2 value.
- denied_count  output  32  saturating count of requester-cycles denied.

Behaviour:
- Reset (async, active-high):
  - cdb_tag1/2 = 0, cdb_value1/2 = 0.
  - rr_ptr = 0, denied_count = 0.
  - req_ready = 0 while reset is asserted.
- Eligible requester: req_valid[i]=1 and tag != 0.
- Zero-tag requester: req_valid[i]=1 with tag == 0 is consumed as a no-op.
  - req_ready[i]=1 in that cycle.
  - Uses no slot, is not broadcast, is not counted as denied.
- Arbitration, combinational within the cycle:
  - Scan indices rr_ptr, rr_ptr+1, ..., wrapping mod NUM_REQ.
  - First eligible requester wins slot 1; second eligible wins slot 2.
  - req_ready[i]=1 only for winners and zero-tag consumers.
- Handshake:
  - A transfer occurs when req_valid[i] and req_ready[i] are both 1.
  - A requester holds valid, tag and value stable until accepted.
  - req_ready never depends on the requester's own value, so there is no combinational loop beyond req_valid and tag.
- Latency: one cycle.
  - Winners in cycle N appear on the cdb outputs in cycle N+1, for exactly one cycle.
  - A slot with no winner drives tag 0 and value 0 in N+1.
  - With a single winner, it always occupies slot 1.
- Round-robin pointer:
  - If any grant occurred, next rr_ptr = (index of the last winner + 1) mod NUM_REQ, wrapping at NUM_REQ-1 back to 0.
  - If no grant occurred, rr_ptr is unchanged.
  - No requester waits more than ceil(NUM_REQ/2) grant cycles.
- denied_count:
  - Each non-flush cycle, adds (number of eligible requesters) minus (number granted).
  - Saturates at 32'hFFFF_FFFF and never wraps.
- Flush:
  - While flush=1, req_ready = 0 and there are no grants.
  - The next cycle's cdb outputs are 0.
  - rr_ptr resets to 0 at the clock edge.
  - denied_count is unchanged.
  - Registered outputs launched before the flush edge still broadcast in their cycle; downstream kills them by tag.
- Reset mid-operation: outputs clear immediately (async) and pending grants are lost. Requesters re-present after reset.
- Duplicate tags from two requesters are illegal. Both are granted as-is; this is an assertion target, not corrected.
- Values are passed through unmodified, with no width conversion.

Test Plan:
- Reset with req_valid=4'b1111 held → all outputs 0 and req_ready=0 during reset; first cycle after release grants req0 (tag 5) and req1 (tag 6); next cycle cdb_tag1=5, cdb_tag2=6.
- All four valid for 4 cycles with tags 10/11/12/13, each requester retiring on accept:
  - Cycle 0 grants 0,1; cycle 1 grants 2,3.
  - CDB shows (10,11) then (12,13).
  - denied_count=2 after cycle 0 and stays 2.
- Only req2 valid (tag 7, value 32'hDEAD_BEEF) → req_ready=4'b0100; next cycle cdb_tag1=7, cdb_value1=32'hDEAD_BEEF, cdb_tag2=0; rr_ptr becomes 3.
- Wrap-around: rr_ptr=3, req3 and req0 valid → req3 on slot 1, req0 on slot 2; rr_ptr becomes 1.
- req1 valid with tag 0 plus req2 tag 9 → req_ready=4'b0110; only tag 9 is broadcast on slot 1; denied_count unchanged.
- flush=1 with all requesters valid → req_ready=0, next-cycle CDB tags 0, rr_ptr=0; after flush drops, req0 and req1 are granted first.
